// File: rtl/color_sel_pkg.sv
// Shared types and width helpers for the multi-player colour picker.
package color_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PICK  = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Palette address width; a single-entry palette still needs one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

  // Width of the player index, wide enough to count to nplayer.
  function automatic int unsigned player_width(input int unsigned nplayer);
    return 32'($clog2(nplayer + 1));
  endfunction

endpackage

// File: rtl/color_next_free.sv
// Rotating search for the nearest free palette index strictly away from start.
module color_next_free #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic [DEPTH-1:0] taken_i,
  input  logic [AW-1:0]    start_i,
  input  logic             dir_i,    // 0: forward, 1: backward
  output logic [AW-1:0]    idx_o,
  output logic             valid_o
);

  // Walk farthest-to-nearest so the nearest free index wins.
  always_comb begin
    int          cand;
    logic [AW-1:0] cand_a;
    cand    = 0;
    cand_a  = '0;
    idx_o   = start_i;
    valid_o = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (dir_i) begin
        cand = (int'(start_i) + int'(DEPTH) - k) % int'(DEPTH);
      end else begin
        cand = (int'(start_i) + k) % int'(DEPTH);
      end
      cand_a = AW'(cand);
      if (!taken_i[cand_a]) begin
        idx_o   = cand_a;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/color_select_multi.sv
// Multi-player palette picker: each player locks a distinct colour in turn.
module color_select_multi
  import color_sel_pkg::*;
#(
  parameter int unsigned NPLAYER   = 2,
  parameter int unsigned PAL_DEPTH = 8,
  parameter int unsigned COLOR_W   = 12,
  parameter int unsigned ADDR_W    = addr_width(PAL_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                en,
  input  logic                                choose,
  input  logic                                rechoose,
  input  logic                                nxtcolor,
  input  logic                                prvcolor,
  input  logic [COLOR_W-1:0]                  body_color,
  input  logic [COLOR_W-1:0]                  head_color,
  output logic [ADDR_W-1:0]                   addr,
  output logic [player_width(NPLAYER)-1:0]    player,
  output logic [PAL_DEPTH-1:0]                taken,
  output logic [NPLAYER*COLOR_W-1:0]          body_out,
  output logic [NPLAYER*COLOR_W-1:0]          head_out,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned PW = player_width(NPLAYER);
  localparam int unsigned SW = NPLAYER * COLOR_W;

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                en_ps_q, en_ps_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PW-1:0]       player_q, player_d;
  logic [PAL_DEPTH-1:0] taken_q, taken_d;
  logic [SW-1:0]       body_q, body_d, head_q, head_d;
  logic [ADDR_W-1:0]   idx_q [NPLAYER];
  logic [ADDR_W-1:0]   idx_d [NPLAYER];
  logic                busy_q, busy_d, done_q, done_d;

  logic [ADDR_W-1:0]   fwd_idx_c, bwd_idx_c;
  logic                fwd_ok_c, bwd_ok_c;
  logic                first_c, last_c;
  logic [ADDR_W-1:0]   prev_idx_c, last_idx_c;

  color_next_free #(.DEPTH(PAL_DEPTH), .AW(ADDR_W)) u_fwd (
    .taken_i (taken_q),
    .start_i (addr_q),
    .dir_i   (1'b0),
    .idx_o   (fwd_idx_c),
    .valid_o (fwd_ok_c)
  );

  color_next_free #(.DEPTH(PAL_DEPTH), .AW(ADDR_W)) u_bwd (
    .taken_i (taken_q),
    .start_i (addr_q),
    .dir_i   (1'b1),
    .idx_o   (bwd_idx_c),
    .valid_o (bwd_ok_c)
  );

  // The edge pulse is registered once more: a round starts three edges after en is first seen.
  assign en_ps_d    = s2_q & ~s3_q;
  assign first_c    = (player_q == '0);
  assign last_c     = (player_q == PW'(NPLAYER - 1));
  assign last_idx_c = idx_q[NPLAYER-1];

  // Chosen index of the player just below the current one.
  always_comb begin
    prev_idx_c = '0;
    for (int unsigned k = 1; k < NPLAYER; k++) begin
      if (player_q == PW'(k)) prev_idx_c = idx_q[k-1];
    end
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      en_ps_q  <= 1'b0;
      addr_q   <= '0;
      player_q <= '0;
      taken_q  <= '0;
      body_q   <= '0;
      head_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int unsigned k = 0; k < NPLAYER; k++) idx_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= en;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      en_ps_q  <= en_ps_d;
      addr_q   <= addr_d;
      player_q <= player_d;
      taken_q  <= taken_d;
      body_q   <= body_d;
      head_q   <= head_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
    end
  end

  // Next state and datapath updates; choose > rechoose > nxtcolor > prvcolor.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    player_d = player_q;
    taken_d  = taken_q;
    body_d   = body_q;
    head_d   = head_q;
    idx_d    = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (en_ps_q) begin
          state_d  = ST_PICK;
          addr_d   = '0;
          player_d = '0;
          taken_d  = '0;
          body_d   = '0;
          head_d   = '0;
          for (int unsigned k = 0; k < NPLAYER; k++) idx_d[k] = '0;
        end
      end

      ST_PICK: begin
        // Live preview (or final capture on choose) of the current player's slot.
        for (int unsigned k = 0; k < NPLAYER; k++) begin
          if (player_q == PW'(k)) begin
            body_d[k*COLOR_W +: COLOR_W] = body_color;
            head_d[k*COLOR_W +: COLOR_W] = head_color;
          end
        end
        if (choose) begin
          taken_d[addr_q] = 1'b1;
          for (int unsigned k = 0; k < NPLAYER; k++) begin
            if (player_q == PW'(k)) idx_d[k] = addr_q;
          end
          if (last_c) begin
            state_d = ST_READY;
          end else begin
            player_d = player_q + PW'(1);
            addr_d   = fwd_idx_c;
          end
        end else if (rechoose) begin
          if (!first_c) begin
            for (int unsigned k = 0; k < NPLAYER; k++) begin
              if (player_q == PW'(k)) begin
                body_d[k*COLOR_W +: COLOR_W] = '0;
                head_d[k*COLOR_W +: COLOR_W] = '0;
              end
            end
            player_d            = player_q - PW'(1);
            taken_d[prev_idx_c] = 1'b0;
            addr_d              = prev_idx_c;
          end
        end else if (nxtcolor) begin
          if (fwd_ok_c) addr_d = fwd_idx_c;
        end else if (prvcolor) begin
          if (bwd_ok_c) addr_d = bwd_idx_c;
        end
      end

      ST_READY: begin
        if (choose) begin
          state_d = ST_DONE;
        end else if (rechoose) begin
          state_d             = ST_PICK;
          taken_d[last_idx_c] = 1'b0;
          addr_d              = last_idx_c;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_PICK) || (state_d == ST_READY);
    done_d = (state_d == ST_DONE);
  end

  assign addr     = addr_q;
  assign player   = player_q;
  assign taken    = taken_q;
  assign body_out = body_q;
  assign head_out = head_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_color_select_multi.sv
// Self-checking bench for color_select_multi with a queue-based reference model.
module tb_color_select_multi;

  localparam int NP = 4;
  localparam int PD = 4;
  localparam int CW = 12;
  localparam int AW = 2;
  localparam int PW = 3;

  logic              clk = 1'b0;
  logic              rstn, en, choose, rechoose, nxtcolor, prvcolor;
  logic [CW-1:0]     body_color, head_color;
  logic [AW-1:0]     addr;
  logic [PW-1:0]     player;
  logic [PD-1:0]     taken;
  logic [NP*CW-1:0]  body_out, head_out;
  logic              busy, done;

  logic [CW-1:0]     pal_b [PD];
  logic [CW-1:0]     pal_h [PD];

  assign body_color = pal_b[addr];
  assign head_color = pal_h[addr];

  always #5 clk = ~clk;

  color_select_multi #(
    .NPLAYER   (NP),
    .PAL_DEPTH (PD),
    .COLOR_W   (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .choose     (choose),
    .rechoose   (rechoose),
    .nxtcolor   (nxtcolor),
    .prvcolor   (prvcolor),
    .body_color (body_color),
    .head_color (head_color),
    .addr       (addr),
    .player     (player),
    .taken      (taken),
    .body_out   (body_out),
    .head_out   (head_out),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_OFF, M_SEL, M_WAIT, M_FIN} mph_t;

  mph_t          m_ph;
  int            m_addr;
  int            m_player;
  int            chosen[$];
  logic [CW-1:0] mb [NP];
  logic [CW-1:0] mh [NP];
  bit            enh [4];
  bit            m_live = 1'b0;

  int errors = 0;
  int checks = 0;

  function automatic bit in_use(input int a);
    foreach (chosen[i]) if (chosen[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int free_step(input int a, input int d);
    for (int k = 1; k < PD; k++) begin
      int c;
      c = (a + d * k + PD) % PD;
      if (!in_use(c)) return c;
    end
    return a;
  endfunction

  function automatic logic [PD-1:0] m_taken();
    logic [PD-1:0] t;
    t = '0;
    foreach (chosen[i]) t[AW'(chosen[i])] = 1'b1;
    return t;
  endfunction

  function automatic logic [NP*CW-1:0] pack_slots(input bit head);
    logic [NP*CW-1:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) v[k*CW +: CW] = head ? mh[k] : mb[k];
    return v;
  endfunction

  // Model advances on every rising edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    bit go;
    int p;
    go = 1'b0;
    p  = 0;
    if (!rstn) begin
      m_live   = 1'b1;
      m_ph     = M_OFF;
      m_addr   = 0;
      m_player = 0;
      chosen.delete();
      for (int k = 0; k < NP; k++) begin mb[k] = '0; mh[k] = '0; end
      for (int k = 0; k < 4; k++) enh[k] = 1'b0;
    end else if (m_live) begin
      go     = enh[2] && !enh[3];
      enh[3] = enh[2];
      enh[2] = enh[1];
      enh[1] = enh[0];
      enh[0] = en;
      case (m_ph)
        M_OFF: begin
          if (go) begin
            m_ph     = M_SEL;
            m_addr   = 0;
            m_player = 0;
            chosen.delete();
            for (int k = 0; k < NP; k++) begin mb[k] = '0; mh[k] = '0; end
          end
        end
        M_SEL: begin
          p = chosen.size();
          mb[p] = pal_b[m_addr];
          mh[p] = pal_h[m_addr];
          if (choose) begin
            chosen.push_back(m_addr);
            if (p == NP - 1) m_ph = M_WAIT;
            else m_addr = free_step(m_addr, 1);
          end else if (rechoose) begin
            if (p > 0) begin
              mb[p]  = '0;
              mh[p]  = '0;
              m_addr = chosen.pop_back();
            end
          end else if (nxtcolor) begin
            m_addr = free_step(m_addr, 1);
          end else if (prvcolor) begin
            m_addr = free_step(m_addr, -1);
          end
          m_player = (m_ph == M_SEL) ? chosen.size() : NP - 1;
        end
        M_WAIT: begin
          if (choose) begin
            m_ph = M_FIN;
          end else if (rechoose) begin
            m_ph     = M_SEL;
            m_addr   = chosen.pop_back();
            m_player = NP - 1;
          end
        end
        default: m_ph = M_OFF;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge, compare all outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("addr",     64'(addr),     64'(m_addr));
      chk("player",   64'(player),   64'(m_player));
      chk("taken",    64'(taken),    64'(m_taken()));
      chk("body_out", 64'(body_out), 64'(pack_slots(1'b0)));
      chk("head_out", 64'(head_out), 64'(pack_slots(1'b1)));
      chk("busy",     64'(busy),     64'((m_ph == M_SEL) || (m_ph == M_WAIT)));
      chk("done",     64'(done),     64'(m_ph == M_FIN));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit c, input bit r, input bit n, input bit p);
    choose   = c;
    rechoose = r;
    nxtcolor = n;
    prvcolor = p;
    @(negedge clk);
    choose   = 1'b0;
    rechoose = 1'b0;
    nxtcolor = 1'b0;
    prvcolor = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < PD; i++) begin
      pal_b[i] = CW'(256 + i);
      pal_h[i] = CW'(2560 + i);
    end
    rstn = 1'b0; en = 1'b0;
    choose = 1'b0; rechoose = 1'b0; nxtcolor = 1'b0; prvcolor = 1'b0;
    idle(2);
    chk("rst_addr",  64'(addr),     64'd0);
    chk("rst_taken", 64'(taken),    64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_body",  64'(body_out), 64'd0);

    // Start latency: PICK after the third edge following the first en sample.
    rstn = 1'b1; en = 1'b1;
    idle(3);
    chk("start_early", 64'(busy), 64'd0);
    idle(1);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_addr", 64'(addr), 64'd0);
    idle(1);
    chk("preview0_body", 64'(body_out[CW-1:0]), 64'h100);
    chk("preview0_head", 64'(head_out[CW-1:0]), 64'hA00);

    pulse(0, 0, 1, 0); pulse(0, 0, 1, 0);
    chk("nxt_to2", 64'(addr), 64'd2);
    pulse(1, 0, 0, 0);
    chk("p0_lock_player", 64'(player), 64'd1);
    chk("p0_lock_taken",  64'(taken),  64'b0100);
    chk("p0_lock_addr",   64'(addr),   64'd3);
    pulse(0, 0, 0, 1);
    chk("prv_to1", 64'(addr), 64'd1);
    pulse(0, 0, 1, 0);
    chk("nxt_skip2", 64'(addr), 64'd3);
    pulse(0, 0, 1, 0);
    chk("nxt_wrap", 64'(addr), 64'd0);
    pulse(0, 0, 0, 1);
    chk("prv_wrap", 64'(addr), 64'd3);

    pulse(0, 1, 0, 0);
    chk("rech_player", 64'(player), 64'd0);
    chk("rech_addr",   64'(addr),   64'd2);
    chk("rech_taken",  64'(taken),  64'd0);
    chk("rech_slot1",  64'(body_out[2*CW-1:CW]), 64'd0);
    pulse(0, 1, 0, 0);
    chk("rech_p0_player", 64'(player), 64'd0);
    chk("rech_p0_addr",   64'(addr),   64'd2);

    pulse(1, 0, 0, 0);
    pulse(1, 0, 1, 0);
    chk("choose_nxt_player", 64'(player), 64'd2);
    chk("choose_nxt_addr",   64'(addr),   64'd0);
    chk("choose_nxt_taken",  64'(taken),  64'b1100);
    pulse(1, 0, 0, 0);
    chk("three_addr",  64'(addr),  64'd1);
    chk("three_taken", 64'(taken), 64'b1101);
    pulse(0, 0, 1, 0);
    chk("single_free_nxt", 64'(addr), 64'd1);
    pulse(0, 0, 0, 1);
    chk("single_free_prv", 64'(addr), 64'd1);

    pulse(1, 0, 0, 0);
    chk("ready_busy",  64'(busy),     64'd1);
    chk("ready_taken", 64'(taken),    64'b1111);
    chk("ready_body",  64'(body_out), 64'h101_100_103_102);
    pulse(0, 0, 1, 0);
    chk("ready_nxt_ignored", 64'(addr), 64'd1);
    pulse(0, 1, 0, 0);
    chk("ready_rech_busy",   64'(busy),   64'd1);
    chk("ready_rech_player", 64'(player), 64'd3);
    chk("ready_rech_taken",  64'(taken),  64'b1101);
    chk("ready_rech_addr",   64'(addr),   64'd1);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    chk("done_high", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    idle(1);
    chk("done_low",   64'(done),  64'd0);
    chk("done_taken", 64'(taken), 64'b1111);
    idle(10);
    chk("held_en_no_restart", 64'(busy), 64'd0);

    // New round, then reset in the middle of it.
    en = 1'b0; idle(2); en = 1'b1; idle(6);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    en = 1'b0; rstn = 1'b0;
    idle(1);
    chk("midrst_addr",   64'(addr),     64'd0);
    chk("midrst_player", 64'(player),   64'd0);
    chk("midrst_taken",  64'(taken),    64'd0);
    chk("midrst_body",   64'(body_out), 64'd0);
    chk("midrst_busy",   64'(busy),     64'd0);
    rstn = 1'b1;
    idle(6);
    chk("midrst_idle", 64'(busy), 64'd0);

    // Randomised phase against the model.
    for (int i = 0; i < PD; i++) begin
      pal_b[i] = CW'($urandom);
      pal_h[i] = CW'($urandom);
    end
    for (int i = 0; i < 4000; i++) begin
      choose   = ($urandom_range(0, 9)  == 0);
      rechoose = ($urandom_range(0, 11) == 0);
      nxtcolor = ($urandom_range(0, 3)  == 0);
      prvcolor = ($urandom_range(0, 3)  == 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 499) == 0) begin
        en   = 1'b0;
        rstn = 1'b0;
      end else begin
        rstn = 1'b1;
      end
      @(negedge clk);
    end
    choose = 1'b0; rechoose = 1'b0; nxtcolor = 1'b0; prvcolor = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
